// File: rtl/disp_scan_reader_if.sv
// Signal bundle of disp_scan_reader: frame control and status, bitmap read port, pixel stream.
// master = scanner side, slave = memory/driver/controller side.
interface disp_scan_reader_if #(
    parameter int COLS = 32,
    parameter int ROWS = 32
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          start;
    logic [9:0]    mem_addr;
    logic          mem_d;
    logic          px_valid;
    logic          px_ready;
    logic          px_d;
    logic [RW-1:0] px_row;
    logic [CW-1:0] px_col;
    logic          px_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, mem_d, px_ready,
        output mem_addr, px_valid, px_d, px_row, px_col, px_last, busy, done
    );

    modport slave (
        output start, mem_d, px_ready,
        input  mem_addr, px_valid, px_d, px_row, px_col, px_last, busy, done
    );
endinterface

// File: rtl/disp_scan_reader.sv
// Row-major read scanner for the 1024x1 display bitmap, producing a tagged valid/ready pixel stream.
// Optional macro SCAN_LOOP_EN: rescan frames continuously after the first start.
module disp_scan_reader #(
    parameter int COLS = 32,
    parameter int ROWS = 32
) (
    input  logic               clk,
    input  logic               rst,
    disp_scan_reader_if.master bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [10:0]   LAST_ADDR = 11'(COLS * ROWS - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   iss_q, iss_d;
    logic [9:0]    addr_q, addr_d;
    logic          f0_q, f0_d;
    logic          f1_q, f1_d;
    logic [1:0]    fifo_q, fifo_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          done_q, done_d;

    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic          remain_s;
    logic          last_pos_s;
    logic          final_pop_s;
    logic [2:0]    occ_s;

    // f0 marks a read whose address is on mem_addr, f1 one whose data sits on mem_d
    assign pop_s       = valid_q & bus.px_ready;
    assign push_s      = f1_q;
    assign last_pos_s  = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign final_pop_s = pop_s & last_pos_s;
    assign occ_s       = {1'b0, cnt_q} + {2'b00, f0_q} + {2'b00, f1_q};
`ifdef SCAN_LOOP_EN
    assign remain_s    = 1'b1;
`else
    assign remain_s    = (iss_q <= LAST_ADDR);
`endif

    // Frame control: start acceptance, read issue decision and done pulse
    always_comb begin
        state_d = state_q;
        issue_s = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    issue_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                issue_s = remain_s && ((occ_s - {2'b00, pop_s}) <= 3'd1);
                if (final_pop_s) begin
                    done_d = 1'b1;
`ifdef SCAN_LOOP_EN
                    state_d = ST_SCAN;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: address counter, read pipeline, 2-entry pixel FIFO and output tag counters
    always_comb begin
        f0_d   = issue_s;
        f1_d   = f0_q;
        fifo_d = fifo_q;
        if (issue_s) begin
            addr_d = iss_q[9:0];
`ifdef SCAN_LOOP_EN
            iss_d  = (iss_q == LAST_ADDR) ? 11'd0 : iss_q + 11'd1;
`else
            iss_d  = iss_q + 11'd1;
`endif
        end else if (state_d == ST_IDLE) begin
            addr_d = addr_q;
            iss_d  = 11'd0;
        end else begin
            addr_d = addr_q;
            iss_d  = iss_q;
        end

        if (push_s) begin
            fifo_d[wr_q] = bus.mem_d;
            wr_d         = ~wr_q;
        end else begin
            wr_d         = wr_q;
        end
        rd_d    = pop_s ? ~rd_q : rd_q;
        cnt_d   = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        valid_d = (cnt_d != 2'd0);

        if (state_q == ST_IDLE) begin
            row_d = {RW{1'b0}};
            col_d = {CW{1'b0}};
        end else if (pop_s) begin
            if (col_q == COL_MAX) begin
                col_d = {CW{1'b0}};
                row_d = (row_q == ROW_MAX) ? {RW{1'b0}} : row_q + RW'(1'b1);
            end else begin
                col_d = col_q + CW'(1'b1);
                row_d = row_q;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // State and datapath registers; reset drops in-flight and buffered pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            iss_q   <= 11'd0;
            addr_q  <= 10'd0;
            f0_q    <= 1'b0;
            f1_q    <= 1'b0;
            fifo_q  <= 2'b00;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            row_q   <= {RW{1'b0}};
            col_q   <= {CW{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            addr_q  <= addr_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            fifo_q  <= fifo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.px_valid = valid_q;
    assign bus.px_d     = fifo_q[rd_q];
    assign bus.px_row   = row_q;
    assign bus.px_col   = col_q;
    assign bus.px_last  = valid_q & last_pos_s;
    assign bus.busy     = (state_q == ST_SCAN);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_disp_scan_reader.sv
// Self-checking bench for disp_scan_reader: bitmap memory model plus pixel scoreboard.
module tb_disp_scan_reader;
    typedef struct {
        logic       d;
        logic [4:0] row;
        logic [4:0] col;
        logic       last;
    } px_t;

`ifdef SCAN_LOOP_EN
    localparam bit LOOP_BUSY = 1'b1;
`else
    localparam bit LOOP_BUSY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    bit          mem [1024];
    px_t         exp_q [$];
    px_t         e;
    int          checks;
    int          failures;
    int          done_cnt;
    logic        held_v;
    logic        fin_pend;
    logic [12:0] held;
    logic [12:0] cur;

    disp_scan_reader_if #(.COLS(32), .ROWS(32)) bus ();

    disp_scan_reader #(.COLS(32), .ROWS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitmap memory: registered read of the scanner address
    always @(posedge clk) bus.mem_d <= mem[bus.mem_addr];

    // Scoreboard: accepted pixels, hold-under-stall and done placement
    always @(negedge clk) begin
        cur = {bus.px_valid, bus.px_d, bus.px_row, bus.px_col, bus.px_last};
        if (rst) begin
            held_v   = 1'b0;
            fin_pend = 1'b0;
        end else begin
            checks++;
            if (fin_pend) begin
                if ({bus.done, bus.busy} !== {1'b1, LOOP_BUSY}) begin
                    failures++;
                    $display("FAIL done_after_last: done,busy=%b%b expected 1%b", bus.done, bus.busy, LOOP_BUSY);
                end
            end else if (bus.done !== 1'b0) begin
                failures++;
                $display("FAIL spurious_done: done=%b expected 0", bus.done);
            end
            if (bus.done === 1'b1) done_cnt++;
            fin_pend = 1'b0;
            if (held_v) begin
                checks++;
                if (cur !== held) begin
                    failures++;
                    $display("FAIL stall_hold: outputs=%h expected %h", cur, held);
                end
            end
            if (bus.px_valid === 1'b1 && bus.px_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_pixel: row=%0d col=%0d accepted, expected none", bus.px_row, bus.px_col);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== {1'b1, e.d, e.row, e.col, e.last}) begin
                        failures++;
                        $display("FAIL pixel: v,d,row,col,last=%h expected %h", cur, {1'b1, e.d, e.row, e.col, e.last});
                    end
                    fin_pend = e.last;
                end
            end
            held_v = (bus.px_valid === 1'b1) && (bus.px_ready !== 1'b1);
            held   = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        px_t p;
        for (int a = 0; a < 1024; a++) begin
            p.d    = mem[a];
            p.row  = 5'(a / 32);
            p.col  = 5'(a % 32);
            p.last = (a == 1023);
            exp_q.push_back(p);
        end
    endtask

    task automatic random_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Drive px_ready at pct% duty until at most 'left' expected pixels remain
    task automatic run_until(input int left, input int pct, input int limit);
        int n;
        n = 0;
        while (exp_q.size() > left && n < limit) begin
            bus.px_ready = ($urandom_range(0, 99) < pct);
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.px_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.px_valid, bus.px_d, bus.px_row, bus.px_col, bus.px_last, bus.mem_addr, bus.busy, bus.done} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs: v=%b d=%b r=%0d c=%0d l=%b a=%0d busy=%b done=%b expected all 0",
                     bus.px_valid, bus.px_d, bus.px_row, bus.px_col, bus.px_last, bus.mem_addr, bus.busy, bus.done);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.px_valid, bus.busy, bus.done, bus.mem_addr} !== 13'd0) begin
            failures++;
            $display("FAIL idle_after_reset: v=%b busy=%b done=%b a=%0d expected 0", bus.px_valid, bus.busy, bus.done, bus.mem_addr);
        end
    endtask

    task automatic test_plain_frame();
        int dc0;
        for (int a = 0; a < 1024; a++) mem[a] = a[0] ^ a[5];
        dc0 = done_cnt;
        bus.px_ready = 1'b1;
        push_frame();
        pulse_start();
        checks++;
        if ({bus.mem_addr, bus.busy, bus.px_valid} !== {10'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL first_issue: addr=%0d busy=%b v=%b expected 0 1 0", bus.mem_addr, bus.busy, bus.px_valid);
        end
        tick();
        checks++;
        if (bus.px_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: v=%b expected 0", bus.px_valid);
        end
        tick();
        checks++;
        if ({bus.px_valid, bus.px_d} !== {1'b1, mem[0]}) begin
            failures++;
            $display("FAIL latency_first: v,d=%b%b expected 1%b", bus.px_valid, bus.px_d, mem[0]);
        end
        run_until(0, 100, 4000);
        checks++;
        if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL plain_end: left=%0d done=%b busy=%b expected 0 1 0", exp_q.size(), bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.px_valid !== 1'b0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL plain_done_once: done=%b v=%b pulses=%0d expected 0 0 1", bus.done, bus.px_valid, done_cnt - dc0);
        end
    endtask

    task automatic test_backpressure();
        int dc0;
        random_mem();
        dc0 = done_cnt;
        push_frame();
        pulse_start();
        run_until(0, 30, 20000);
        tick();
        checks++;
        if (exp_q.size() != 0 || done_cnt != dc0 + 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_frame: left=%0d pulses=%0d busy=%b expected 0 1 0", exp_q.size(), done_cnt - dc0, bus.busy);
        end
    endtask

    task automatic test_stall_start();
        int dc0;
        random_mem();
        dc0 = done_cnt;
        bus.px_ready = 1'b0;
        push_frame();
        pulse_start();
        repeat (20) tick();
        checks++;
        if ({bus.mem_addr, bus.px_valid, bus.px_d} !== {10'd1, 1'b1, mem[0]}) begin
            failures++;
            $display("FAIL stall_reads: addr=%0d v=%b d=%b expected 1 1 %b", bus.mem_addr, bus.px_valid, bus.px_d, mem[0]);
        end
        run_until(0, 100, 4000);
        tick();
        checks++;
        if (exp_q.size() != 0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL stall_frame: left=%0d pulses=%0d expected 0 1", exp_q.size(), done_cnt - dc0);
        end
    endtask

    task automatic test_start_while_busy();
        int dc0;
        random_mem();
        dc0 = done_cnt;
        push_frame();
        pulse_start();
        run_until(924, 100, 1000);
        bus.start = 1'b1;
        repeat (3) tick();
        bus.start = 1'b0;
        run_until(0, 100, 4000);
        repeat (6) tick();
        checks++;
        if (exp_q.size() != 0 || done_cnt != dc0 + 1 || bus.busy !== 1'b0 || bus.px_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored: left=%0d pulses=%0d busy=%b v=%b expected 0 1 0 0",
                     exp_q.size(), done_cnt - dc0, bus.busy, bus.px_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dc0;
        random_mem();
        mem[0] = 1'b1;
        dc0 = done_cnt;
        push_frame();
        pulse_start();
        run_until(524, 100, 4000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if ({bus.px_valid, bus.busy, bus.mem_addr, bus.done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid: v=%b busy=%b addr=%0d done=%b expected 0", bus.px_valid, bus.busy, bus.mem_addr, bus.done);
        end
        repeat (4) tick();
        checks++;
        if (done_cnt != dc0 || bus.px_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: pulses=%0d v=%b expected 0 0", done_cnt - dc0, bus.px_valid);
        end
        bus.px_ready = 1'b1;
        push_frame();
        pulse_start();
        repeat (2) tick();
        checks++;
        if ({bus.px_valid, bus.px_d} !== 2'b11) begin
            failures++;
            $display("FAIL restart_first: v,d=%b%b expected 11", bus.px_valid, bus.px_d);
        end
        run_until(0, 100, 4000);
        tick();
        checks++;
        if (exp_q.size() != 0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL restart_frame: left=%0d pulses=%0d expected 0 1", exp_q.size(), done_cnt - dc0);
        end
    endtask

    task automatic test_loop();
        int dc0;
        random_mem();
        dc0 = done_cnt;
        bus.px_ready = 1'b1;
        push_frame();
        push_frame();
        pulse_start();
        run_until(0, 100, 8000);
        bus.px_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL loop_second_end: left=%0d done=%b busy=%b expected 0 1 1", exp_q.size(), bus.done, bus.busy);
        end
        tick();
        checks++;
        if (done_cnt != dc0 + 2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL loop_pulses: pulses=%0d busy=%b expected 2 1", done_cnt - dc0, bus.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.px_valid} !== 2'b00) begin
            failures++;
            $display("FAIL loop_reset: busy=%b v=%b expected 0 0", bus.busy, bus.px_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        held_v   = 1'b0;
        fin_pend = 1'b0;
        rst      = 1'b1;
        bus.start    = 1'b0;
        bus.px_ready = 1'b0;
        test_reset();
`ifdef SCAN_LOOP_EN
        test_loop();
`else
        test_plain_frame();
        test_backpressure();
        test_stall_start();
        test_start_while_busy();
        test_reset_mid_frame();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
